decoder_scan_ctrl: RTL and testbench
====================================

// Module: decoder_scan_ctrl
// PURPOSE
//   Channel-scan sequencer that sits directly upstream of the 3-to-8 decoder and
//   drives its 3-bit select and enable. It steps through a masked set of the 8
//   channels, lowest to highest. Each channel gets a programmable dwell (enable
//   high), preceded by a fixed blanking gap (enable low) to prevent ghosting
//   between channels. Supports single-sweep and continuous modes.
// PARAMETERS
//   DWELL_W    8   width of dwell_len; dwell counter width
//   BLANK_CYC  2   enable-low cycles before each dwell (0 = no blanking)
// PORTS
//   clk         in   1        single clock, rising edge
//   rst         in   1        asynchronous, active-high reset
//   start       in   1        begin scan; sampled only in IDLE
//   stop        in   1        abort scan; priority over start
//   mode_cont   in   1        1 = wrap after last channel; 0 = single sweep
//   ch_mask     in   8        channels to visit; latched at accepted start
//   dwell_len   in   DWELL_W  dwell cycles per channel; latched at start; 0 treated as 1
//   sel         out  3        channel index to decoder 'in'
//   sel_en      out  1        decoder enable; high only during DWELL
//   busy        out  1        high while not IDLE
//   sweep_done  out  1        1-cycle pulse at the end of each full sweep
// BEHAVIOUR
//   - All outputs registered. Reset values: sel=0, sel_en=0, busy=0,
//     sweep_done=0, FSM=IDLE, counters=0, latched mask/dwell=0.
//   - FSM states: IDLE, BLANK, DWELL.
//   - IDLE: start=1, stop=0, ch_mask!=0 at edge N -> latch mask and dwell
//     (0 becomes 1); sel=lowest set bit; busy=1 after edge N.
//     Next state: BLANK if BLANK_CYC>0, else DWELL.
//     start with ch_mask==0 is ignored (stay IDLE, no pulse).
//   - BLANK: sel_en=0, sel already holds the upcoming channel; lasts exactly
//     BLANK_CYC cycles, then DWELL.
//   - DWELL: sel_en=1 for exactly dwell_len cycles with sel stable.
//     At the last dwell cycle, next = lowest latched-mask bit above sel.
//       found     -> sel=next; enter BLANK (or DWELL if BLANK_CYC=0).
//       not found -> sweep_done=1 for one cycle, coincident with the first
//                    cycle after the final dwell. mode_cont is sampled at
//                    this point:
//                    1 -> sel=lowest set bit; re-enter BLANK/DWELL; busy stays 1.
//                    0 -> IDLE; busy=0 and sel_en=0 in the same cycle.
//   - Timing: start accepted at edge N -> sel_en first high after edge
//     N+BLANK_CYC. Channel-to-channel period = BLANK_CYC + dwell_len.
//   - stop=1 in any non-IDLE state -> IDLE at next edge; sel_en=0, busy=0,
//     no sweep_done; sel holds its last value. stop in IDLE has no effect.
//   - start while busy is ignored. ch_mask and dwell_len changes mid-scan
//     have no effect until the next accepted start.
//   - Single-bit mask: one channel per sweep; sweep_done after every dwell.
//     Continuous mode re-blanks between repeats.
//   - sel_en is never high in the same cycle that sel changes (glitch-free
//     one-hot at the decoder). With BLANK_CYC=0 this rule is waived.
//   - Async rst mid-scan: outputs go to reset values immediately.
// TESTING
//   1. Reset: assert rst mid-DWELL -> sel_en, busy, sel, sweep_done go 0 immediately.
//   2. Single sweep: mask=8'b1010_0100, dwell=3, BLANK_CYC=2 -> sel 2,5,7;
//      each with 2 cycles en=0 then 3 cycles en=1; sweep_done once; busy=0 after.
//   3. Continuous: mask=8'h81, dwell=1, mode_cont=1 -> sel 0,7,0,7...;
//      sweep_done every 6 cycles; busy stays 1.
//   4. Stop: mask=8'hFF; stop during ch 3 dwell -> next cycle IDLE,
//      sel_en=0, no sweep_done; start in the same cycle as stop is ignored.
//   5. Edge inputs: mask=0 start -> busy stays 0. dwell=0 -> 1-cycle dwell.
//      start while busy is ignored. A mid-scan mask change does not alter
//      the sequence.
//   6. BLANK_CYC=0: mask=8'h03, dwell=2 -> sel_en high 4 contiguous cycles,
//      sel 0->1 after 2 cycles.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// Channel-scan sequencer for a 3-to-8 decoder: walks a latched channel mask
// lowest to highest, each channel getting a blanking gap then a dwell.
module decoder_scan_ctrl #(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [7:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell_len,
    output logic [2:0]         sel,
    output logic               sel_en,
    output logic               busy,
    output logic               sweep_done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] DWELL = 2'd2;

    localparam bit HAS_BLANK = (BLANK_CYC > 0);
    localparam int BW        = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int BLAST     = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

    logic [1:0]         state;
    logic [BW-1:0]      blank_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [7:0]         mask_q;

    logic [2:0] first_in, first_q, nxt, enter_sel;
    logic       found, dwell_last, accept, enter;

    function automatic logic [2:0] lowbit(input logic [7:0] m);
        lowbit = '0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowbit = i[2:0];
    endfunction

    always_comb begin
        first_in = lowbit(ch_mask);
        first_q  = lowbit(mask_q);
        nxt      = '0;
        found    = 1'b0;
        // Descending scan so the lowest qualifying channel wins.
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && i > int'(sel)) begin
                nxt   = i[2:0];
                found = 1'b1;
            end
        end
        dwell_last = (state == DWELL) && (dwell_cnt == dwell_q - DWELL_W'(1));
        accept     = (state == IDLE) && start && !stop && (ch_mask != 8'h00);
        enter      = accept ||
                     ((state != IDLE) && !stop && dwell_last && (found || mode_cont));
        enter_sel  = accept ? first_in : (found ? nxt : first_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            blank_cnt  <= '0;
            dwell_cnt  <= '0;
            dwell_q    <= '0;
            mask_q     <= '0;
            sel        <= '0;
            sel_en     <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (enter) begin
                sel  <= enter_sel;
                busy <= 1'b1;
                if (accept) begin
                    mask_q  <= ch_mask;
                    dwell_q <= (dwell_len == '0) ? DWELL_W'(1) : dwell_len;
                end
                if (dwell_last && !found) sweep_done <= 1'b1;
                if (HAS_BLANK) begin
                    state     <= BLANK;
                    blank_cnt <= '0;
                    sel_en    <= 1'b0;
                end else begin
                    state     <= DWELL;
                    dwell_cnt <= '0;
                    sel_en    <= 1'b1;
                end
            end else if (state != IDLE) begin
                if (stop) begin
                    state  <= IDLE;
                    sel_en <= 1'b0;
                    busy   <= 1'b0;
                end else if (state == BLANK) begin
                    if (blank_cnt == BLAST[BW-1:0]) begin
                        state     <= DWELL;
                        dwell_cnt <= '0;
                        sel_en    <= 1'b1;
                    end else begin
                        blank_cnt <= blank_cnt + BW'(1);
                    end
                end else if (dwell_last) begin
                    // End of a single sweep: drop back to idle with the pulse.
                    state      <= IDLE;
                    sel_en     <= 1'b0;
                    busy       <= 1'b0;
                    sweep_done <= 1'b1;
                end else begin
                    dwell_cnt <= dwell_cnt + DWELL_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: one instance with blanking, one without.
module tb_decoder_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, mode_cont = 1'b0;
    logic [7:0] ch_mask = 8'h00, dwell_len = 8'd0;
    logic [2:0] sel;
    logic       sel_en, busy, sweep_done;

    logic       start1 = 1'b0;
    logic [7:0] ch_mask1 = 8'h00, dwell_len1 = 8'd0;
    logic [2:0] sel1;
    logic       sel_en1, busy1, sweep_done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYC(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
        .ch_mask(ch_mask), .dwell_len(dwell_len),
        .sel(sel), .sel_en(sel_en), .busy(busy), .sweep_done(sweep_done)
    );

    decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYC(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start1), .stop(1'b0), .mode_cont(1'b0),
        .ch_mask(ch_mask1), .dwell_len(dwell_len1),
        .sel(sel1), .sel_en(sel_en1), .busy(busy1), .sweep_done(sweep_done1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int s, input int en, input int b, input int sd);
        chk({tag, ".sel"},  int'(sel), s);
        chk({tag, ".en"},   int'(sel_en), en);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".sd"},   int'(sweep_done), sd);
    endtask

    initial begin
        int chs[3];
        #12;
        chk_out("reset", 0, 0, 0, 0);
        rst = 1'b0;
        step();

        // Single sweep, mask A4, dwell 3; mid-scan start/mask/dwell change ignored
        chs = '{2, 5, 7};
        ch_mask = 8'hA4; dwell_len = 8'd3; mode_cont = 1'b0; start = 1'b1;
        foreach (chs[k]) begin
            if (k == 1) begin
                ch_mask = 8'hFF; dwell_len = 8'd7; start = 1'b1;
            end
            for (int b = 0; b < 2; b++) begin
                step(); start = 1'b0;
                chk_out("sweep.blank", chs[k], 0, 1, 0);
            end
            for (int d = 0; d < 3; d++) begin
                step();
                chk_out("sweep.dwell", chs[k], 1, 1, 0);
            end
        end
        step();
        chk_out("sweep.done", 7, 0, 0, 1);
        step();
        chk_out("sweep.idle", 7, 0, 0, 0);

        // Continuous, mask 81, dwell 1: 0,7,0,7 with sweep_done every 6 cycles
        ch_mask = 8'h81; dwell_len = 8'd1; mode_cont = 1'b1; start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                for (int b = 0; b < 2; b++) begin
                    step(); start = 1'b0;
                    chk_out("cont.blank", c * 7, 0, 1, (r > 0 && c == 0 && b == 0) ? 1 : 0);
                end
                step();
                chk_out("cont.dwell", c * 7, 1, 1, 0);
            end
        end
        // Stop on the final dwell beats the wrap: no pulse, sel holds
        stop = 1'b1;
        step(); stop = 1'b0; mode_cont = 1'b0;
        chk_out("cont.stop", 7, 0, 0, 0);

        // Stop during ch 3 dwell with start asserted in the same cycle
        ch_mask = 8'hFF; dwell_len = 8'd2; start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 2; b++) begin
                step(); start = 1'b0;
                chk_out("stop.blank", c, 0, 1, 0);
            end
            for (int d = 0; d < ((c == 3) ? 1 : 2); d++) begin
                step();
                chk_out("stop.dwell", c, 1, 1, 0);
            end
        end
        stop = 1'b1; start = 1'b1;
        step(); stop = 1'b0; start = 1'b0;
        chk_out("stop.idle", 3, 0, 0, 0);
        step();
        chk_out("stop.stay", 3, 0, 0, 0);

        // Empty mask start is ignored
        ch_mask = 8'h00; start = 1'b1;
        step();
        chk_out("mask0", 3, 0, 0, 0);
        step(); start = 1'b0;
        chk_out("mask0.2", 3, 0, 0, 0);

        // Zero dwell behaves as a one-cycle dwell
        ch_mask = 8'h10; dwell_len = 8'd0; start = 1'b1;
        step(); start = 1'b0;
        chk_out("dw0.b0", 4, 0, 1, 0);
        step();
        chk_out("dw0.b1", 4, 0, 1, 0);
        step();
        chk_out("dw0.dwell", 4, 1, 1, 0);
        step();
        chk_out("dw0.done", 4, 0, 0, 1);

        // No blanking: mask 03, dwell 2 -> four contiguous enable cycles
        ch_mask1 = 8'h03; dwell_len1 = 8'd2; start1 = 1'b1;
        step(); start1 = 1'b0;
        chk("nb.c0.sel", int'(sel1), 0); chk("nb.c0.en", int'(sel_en1), 1);
        chk("nb.c0.busy", int'(busy1), 1);
        step();
        chk("nb.c1.sel", int'(sel1), 0); chk("nb.c1.en", int'(sel_en1), 1);
        step();
        chk("nb.c2.sel", int'(sel1), 1); chk("nb.c2.en", int'(sel_en1), 1);
        step();
        chk("nb.c3.sel", int'(sel1), 1); chk("nb.c3.en", int'(sel_en1), 1);
        step();
        chk("nb.end.en", int'(sel_en1), 0); chk("nb.end.busy", int'(busy1), 0);
        chk("nb.end.sd", int'(sweep_done1), 1); chk("nb.end.sel", int'(sel1), 1);

        // Async reset in the middle of a dwell clears outputs without a clock edge
        ch_mask = 8'h08; dwell_len = 8'd5; start = 1'b1;
        step(); start = 1'b0;
        step();
        step();
        chk_out("rst.pre", 3, 1, 1, 0);
        rst = 1'b1;
        #2;
        chk_out("rst.async", 0, 0, 0, 0);
        step();
        chk_out("rst.hold", 0, 0, 0, 0);
        rst = 1'b0;
        step();
        chk_out("rst.after", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
